// File: rtl/afg_pkg.sv
// Shared types and constants for the game-logic blocks (enemy trackers, hitbox checks).
package afg_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    FLASH,
    EXPLODE,
    DEAD
  } state_t;

  localparam logic [5:0] LVL_START = 6'b000001;
  localparam logic [5:0] LVL_1     = 6'b000010;
  localparam logic [5:0] LVL_2     = 6'b000100;

  // Larger minus smaller, so the 10-bit difference never wraps.
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
  endfunction

endpackage

// File: rtl/hitbox_cmp.sv
// Combinational box overlap: true when point b lies within +/-half of point a on both axes.
module hitbox_cmp
  import afg_pkg::*;
(
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] half_w,
  input  logic [9:0] half_h,
  output logic       overlap
);

  coord_t dx, dy;

  assign dx      = abs_diff(ax, bx);
  assign dy      = abs_diff(ay, by);
  assign overlap = (dx <= half_w) && (dy <= half_h);

endmodule

// File: rtl/enemy_hit_tracker.sv
// Per-enemy hit/health/explosion tracker: consumes enemy and bullet positions,
// produces sprite selection, bullet retire and kill/dead flags.
module enemy_hit_tracker
  import afg_pkg::*;
#(
  parameter int HP           = 2,
  parameter int HALF_W       = 25,
  parameter int HALF_H       = 30,
  parameter int FLASH_FRAMES = 4,
  parameter int EXPL_FRAMES  = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [5:0] level,
  input  logic [5:0] jetlevel,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic       bullet_active,
  output logic       enemy_visible,
  output logic       exploding,
  output logic [1:0] expl_step,
  output logic       bullet_hit,
  output logic       kill_pulse,
  output logic       enemy_dead
);

  localparam int TW = 8;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [2:0]      health, health_nx;
  logic [1:0]      step, step_nx;
  logic            hit_nx, kill_nx;
  logic            overlap, match, start;

  hitbox_cmp u_hitbox (
    .ax      (EnemyX),
    .ay      (EnemyY),
    .bx      (BulletX),
    .by      (BulletY),
    .half_w  (10'(HALF_W)),
    .half_h  (10'(HALF_H)),
    .overlap (overlap)
  );

  assign start = (level == LVL_START);
  assign match = (level == jetlevel);

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    health_nx = health;
    step_nx   = step;
    hit_nx    = 1'b0;
    kill_nx   = 1'b0;
    // Start screen wins over anything the enemy is doing, including a hit.
    if (start) begin
      state_nx  = IDLE;
      timer_nx  = '0;
      health_nx = 3'(HP);
      step_nx   = '0;
    end else begin
      case (state)
        IDLE: if (match) state_nx = ALIVE;
        ALIVE: begin
          if (match && bullet_active && overlap) begin
            hit_nx   = 1'b1;
            timer_nx = '0;
            if (health == 3'd1) begin
              state_nx  = EXPLODE;
              health_nx = '0;
              step_nx   = '0;
              kill_nx   = 1'b1;
            end else begin
              state_nx  = FLASH;
              health_nx = health - 3'd1;
            end
          end
        end
        FLASH: begin
          if (match) begin
            if (timer == TW'(FLASH_FRAMES - 1)) begin
              state_nx = ALIVE;
              timer_nx = '0;
            end else begin
              timer_nx = timer + 1'b1;
            end
          end
        end
        // The explosion runs to completion even if the level changes underneath it.
        EXPLODE: begin
          if (timer == TW'(EXPL_FRAMES - 1)) begin
            timer_nx = '0;
            if (step == 2'd3) state_nx = DEAD;
            else              step_nx  = step + 2'd1;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        DEAD: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      timer      <= '0;
      health     <= 3'(HP);
      step       <= '0;
      bullet_hit <= 1'b0;
      kill_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      health     <= health_nx;
      step       <= step_nx;
      bullet_hit <= hit_nx;
      kill_pulse <= kill_nx;
    end
  end

  // Flash blink follows the frame counter: frame 0 hidden, frame 1 shown, ...
  assign enemy_visible = match && !start &&
                         ((state == ALIVE) || ((state == FLASH) && timer[0]));
  assign exploding     = (state == EXPLODE);
  assign expl_step     = exploding ? step : 2'd0;
  assign enemy_dead    = (state == DEAD);

endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Bench for enemy_hit_tracker: directed scenarios with pinned literals, then random traffic,
// all compared every cycle against a frame-count model of the enemy's life.
module tb_enemy_hit_tracker;
  import afg_pkg::*;

  localparam int HP = 2, HW = 25, HH = 30, FF = 4, EF = 6;
  localparam int M_IDLE = 0, M_ALIVE = 1, M_FLASH = 2, M_EXPL = 3, M_DEAD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] level, jetlevel;
  logic [9:0] ex, ey, bx, by;
  logic       bact;
  logic       vis, expl, hit, kill, dead;
  logic [1:0] step;

  always #5 clk = ~clk;

  enemy_hit_tracker #(
    .HP(HP), .HALF_W(HW), .HALF_H(HH), .FLASH_FRAMES(FF), .EXPL_FRAMES(EF)
  ) dut (
    .frame_clk     (clk),
    .Reset         (rst),
    .level         (level),
    .jetlevel      (jetlevel),
    .EnemyX        (ex),
    .EnemyY        (ey),
    .BulletX       (bx),
    .BulletY       (by),
    .bullet_active (bact),
    .enemy_visible (vis),
    .exploding     (expl),
    .expl_step     (step),
    .bullet_hit    (hit),
    .kill_pulse    (kill),
    .enemy_dead    (dead)
  );

  int n_run = 0, n_fail = 0;
  int tag = 0;
  bit armed = 0;

  // Model: which phase of life, remaining health, frames spent in the phase.
  int m_st = M_IDLE, m_health = HP, m_el = 0;
  int m_hit = 0, m_kill = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit m_overlap();
    return bact && iabs(int'(bx) - int'(ex)) <= HW && iabs(int'(by) - int'(ey)) <= HH;
  endfunction

  task automatic model_update();
    bit mt = (level == jetlevel);
    bit ov = m_overlap();
    m_hit = 0; m_kill = 0;
    if (rst || level == LVL_START) begin
      m_st = M_IDLE; m_health = HP; m_el = 0;
    end else begin
      case (m_st)
        M_IDLE:  if (mt) begin m_st = M_ALIVE; m_el = 0; end
        M_ALIVE: if (mt && ov) begin
          m_hit = 1; m_el = 0; m_health--;
          if (m_health == 0) begin m_st = M_EXPL; m_kill = 1; end
          else m_st = M_FLASH;
        end
        M_FLASH: if (mt) begin
          m_el++;
          if (m_el == FF) begin m_st = M_ALIVE; m_el = 0; end
        end
        M_EXPL: begin
          m_el++;
          if (m_el == 4 * EF) m_st = M_DEAD;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit mt = (level == jetlevel) && (level != LVL_START);
    int e_vis = (mt && (m_st == M_ALIVE || (m_st == M_FLASH && m_el % 2 == 1))) ? 1 : 0;
    int all = int'({vis, expl, step, hit, kill, dead});
    chk("enemy_visible", int'(vis), e_vis);
    chk("exploding", int'(expl), int'(m_st == M_EXPL));
    chk("expl_step", int'(step), (m_st == M_EXPL) ? m_el / EF : 0);
    chk("bullet_hit", int'(hit), m_hit);
    chk("kill_pulse", int'(kill), m_kill);
    chk("enemy_dead", int'(dead), int'(m_st == M_DEAD));
    case (tag)
      1:  chk("lit_reset_outputs", all, 0);
      2:  chk("lit_alive_visible", int'(vis), 1);
      3:  begin chk("lit_hit_pulse", int'(hit), 1); chk("lit_hit_nokill", int'(kill), 0);
                chk("lit_flash0_hidden", int'(vis), 0); end
      4:  begin chk("lit_flash1_shown", int'(vis), 1); chk("lit_flash1_nohit", int'(hit), 0); end
      5:  begin chk("lit_flash2_hidden", int'(vis), 0); chk("lit_flash2_nohit", int'(hit), 0); end
      6:  begin chk("lit_flash3_shown", int'(vis), 1); chk("lit_flash3_nohit", int'(hit), 0); end
      7:  begin chk("lit_back_alive", int'(vis), 1); chk("lit_back_nohit", int'(hit), 0); end
      8:  chk("lit_edge_miss", int'(hit), 0);
      9:  begin chk("lit_kill_hit", int'(hit), 1); chk("lit_kill_pulse", int'(kill), 1);
                chk("lit_kill_expl", int'(expl), 1); chk("lit_kill_step", int'(step), 0);
                chk("lit_kill_hidden", int'(vis), 0); end
      10, 11, 12: chk("lit_expl_step", int'(step), tag - 9);
      13: begin chk("lit_dead", int'(dead), 1); chk("lit_dead_others", all, 1); end
      14: begin chk("lit_mismatch_hidden", int'(vis), 0); chk("lit_mismatch_nohit", int'(hit), 0); end
      15: chk("lit_resume_visible", int'(vis), 1);
      16: chk("lit_start_screen_all0", all, 0);
      17: chk("lit_reset_beats_hit", all, 0);
      default: ;
    endcase
  endtask

  initial forever begin
    @(negedge clk);
    if (armed) compare();
  end

  task automatic tick(input int t);
    @(posedge clk);
    model_update();
    tag = t;
    @(negedge clk);
    #1;
    tag = 0;
  endtask

  task automatic aim(input int dx, input int dy);
    int tx = int'(ex) + dx;
    int ty = int'(ey) + dy;
    if (tx < 0) tx = 0;
    if (tx > 1023) tx = 1023;
    if (ty < 0) ty = 0;
    if (ty > 1023) ty = 1023;
    bx = 10'(tx);
    by = 10'(ty);
  endtask

  initial begin
    rst = 1'b1; level = LVL_START; jetlevel = LVL_1;
    ex = 10'd320; ey = 10'd100; bx = '0; by = '0; bact = 1'b0;
    tick(0);
    armed = 1'b1;
    tick(1);
    rst = 1'b0; level = LVL_1;
    tick(2);
    // First hit on the exact hitbox corner, bullet left overlapping through the flash.
    bx = 10'd345; by = 10'd130; bact = 1'b1;
    tick(3); tick(4); tick(5); tick(6);
    bact = 1'b0;
    tick(7);
    bx = 10'd346; by = 10'd100; bact = 1'b1; tick(8);
    bx = 10'd320; by = 10'd131; tick(8);
    bx = 10'd295; by = 10'd70;  tick(9);
    bact = 1'b0;
    for (int i = 1; i <= 23; i++) tick(i == 6 ? 10 : i == 12 ? 11 : i == 18 ? 12 : 0);
    tick(13);
    tick(13);
    level = LVL_START; tick(16);
    level = LVL_1; tick(2);
    // Level mismatch while alive: hidden and no hit despite overlap.
    level = LVL_2; bx = ex; by = ey; bact = 1'b1;
    tick(14); tick(14);
    level = LVL_1; bact = 1'b0;
    tick(15);
    bact = 1'b1;
    tick(3); tick(0); tick(0); tick(0); tick(0);
    tick(9);
    bact = 1'b0;
    tick(0); tick(0); tick(0);
    level = LVL_START; tick(16);
    level = LVL_1; tick(2);
    bact = 1'b1; rst = 1'b1; tick(17);
    rst = 1'b0; bact = 1'b0; tick(0);

    for (int c = 0; c < 4000; c++) begin
      int r;
      rst = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      level = (r < 3) ? LVL_START : (r < 15) ? LVL_2 : LVL_1;
      if ($urandom_range(0, 49) == 0) jetlevel = $urandom_range(0, 1) ? LVL_2 : LVL_1;
      if ($urandom_range(0, 15) == 0) begin
        ex = 10'($urandom_range(0, 1023));
        ey = 10'($urandom_range(0, 1023));
      end
      aim(int'($urandom_range(0, 72)) - 36, int'($urandom_range(0, 84)) - 42);
      bact = ($urandom_range(0, 3) != 0);
      tick(0);
    end

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_hit_tracker.md
Name: enemy_hit_tracker

Overview:
- Consumer end of the enemy position interface: takes one enemy's EnemyX/EnemyY/phase stream plus the player bullet position and decides hits, health, explosion animation and death.
- Instantiated once per enemy_level instance, next to it, in the top-level game logic.
- Outputs drive the color mapper (visibility, explosion frame), the bullet logic (bullet consume) and the score/level-clear logic.

Parameters:
- HP, 2, hits needed to destroy the enemy (range 1..7).
- HALF_W, 25, hitbox half-width in pixels; matches the 50-pixel enemy sprite.
- HALF_H, 30, hitbox half-height in pixels.
- FLASH_FRAMES, 4, invulnerable flash duration after a non-fatal hit.
- EXPL_FRAMES, 6, frames per explosion animation step (4 steps total).

Ports:
- frame_clk  in  1  frame-rate clock (one tick per video frame).
- Reset  in  1  reset.
- level  in  6  current one-hot game level; 6'b000001 = start screen.
- jetlevel  in  6  level in which this enemy is active.
- EnemyX  in  10  enemy centre X, unsigned.
- EnemyY  in  10  enemy centre Y, unsigned.
- BulletX  in  10  player bullet centre X.
- BulletY  in  10  player bullet centre Y.
- bullet_active  in  1  bullet currently in flight.
- enemy_visible  out  1  the color mapper draws the enemy sprite.
- exploding  out  1  the color mapper draws the explosion sprite.
- expl_step  out  2  explosion sprite index, 0..3.
- bullet_hit  out  1  one-cycle pulse; bullet logic must retire the bullet.
- kill_pulse  out  1  one-cycle pulse when the enemy is destroyed (score +1).
- enemy_dead  out  1  enemy finished; level-clear logic ANDs these together.

Behaviour:
- Clock and reset (already decided): one clock, frame_clk. Reset is synchronous and active-high. All state updates on posedge frame_clk.
- Reset, or level==6'b000001:
  - state=IDLE, health=HP, timer=0.
  - All outputs 0.
- States and transitions:
  - IDLE → ALIVE when level==jetlevel.
  - ALIVE:
    - enemy_visible=1.
    - A hit is bullet_active && |BulletX-EnemyX|<=HALF_W && |BulletY-EnemyY|<=HALF_H.
    - Compute each absolute difference by comparing operands first (larger minus smaller) in 10-bit unsigned arithmetic. No signed wrap.
    - On a hit, bullet_hit=1 on the next cycle.
    - If health==1 → EXPLODE, with health=0, timer=0, expl_step=0, kill_pulse=1 on the same edge as bullet_hit.
    - Otherwise health-=1 → FLASH, with timer=0.
  - FLASH:
    - enemy_visible toggles every frame, starting at 0.
    - Hits are ignored: no bullet_hit, the bullet passes through.
    - After FLASH_FRAMES frames → ALIVE, enemy_visible=1.
  - EXPLODE:
    - exploding=1, enemy_visible=0.
    - timer counts 0..EXPL_FRAMES-1. At wrap, expl_step+=1.
    - After step 3 completes → DEAD.
    - Total 4*EXPL_FRAMES frames.
  - DEAD:
    - enemy_dead=1; every other output 0.
    - Stays until Reset or the start screen.
- level!=jetlevel while in ALIVE/FLASH:
  - Freeze state and timer, enemy_visible=0, no hit detection.
  - Resume when the levels match again.
- In EXPLODE/DEAD, level mismatch does not freeze: the animation completes.
- bullet_hit and kill_pulse are registered one-cycle pulses and never stay high two consecutive cycles.
- Total latency from bullet overlap to the outputs is 1 frame_clk.
- Hitbox edges: at exactly distance HALF_W or HALF_H it is a hit; at HALF+1 it is a miss.
- Reset beats every other event in the same cycle. The start-screen level beats a simultaneous hit.

Decomposition:
- Package afg_pkg holds:
  - the state enum (IDLE, ALIVE, FLASH, EXPLODE, DEAD);
  - the level constants LVL_START=6'b000001, LVL_1=6'b000010, LVL_2=6'b000100;
  - the 10-bit coordinate typedef.
- One sub-module, hitbox_cmp: purely combinational; takes two points and the half sizes, outputs overlap. Reused later for enemy-bullet vs jet.

Test Plan:
1. Reset, then level=jetlevel=2, Enemy(320,100), Bullet(345,130) active → bullet_hit pulses 1 cycle; state FLASH; enemy_visible toggles 0,1,0,1; ALIVE after 4 frames.
2. Bullet(346,100) → no hit. Bullet(320,131) → no hit. Bullet(295,70) → hit.
3. With HP=2: hit, wait out the flash, hit again → kill_pulse and bullet_hit on the same cycle; exploding=1; expl_step 0,1,2,3 each held 6 frames; enemy_dead=1 at frame 24.
4. Bullet overlapping continuously during FLASH → exactly one bullet_hit, health decremented once.
5. level=4, jetlevel=2 while ALIVE → enemy_visible=0, overlapping bullet gives no hit; restore level=2 → state resumes.
6. Mid-explosion level=6'b000001 → next cycle IDLE, all outputs 0. Reset asserted together with a hit → no bullet_hit pulse.
